// File: rtl/dac_pattern_src.sv
// Burst-controlled sample source for the 5-to-2 DAC interface: emits one LANES x W frame per cycle,
// either passed through from upstream or generated (ramp, square, constant), midscale when idle.
module dac_pattern_src #(
    parameter int W             = 14,
    parameter int LANES         = 5,
    parameter int OFFSET_BINARY = 1
) (
    input  logic               sysclk_in,
    input  logic               reset,
    input  logic               arm,
    input  logic               trigger,
    input  logic               abort,
    input  logic [1:0]         mode,
    input  logic [15:0]        burst_len,
    input  logic [W-1:0]       ramp_step,
    input  logic [7:0]         sq_half,
    input  logic [W-1:0]       const_val,
    input  logic [LANES*W-1:0] src_data,
    input  logic               src_valid,
    output logic [LANES*W-1:0] data_out,
    output logic               busy,
    output logic [15:0]        underflow_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam logic [W-1:0] MSB_MASK = (OFFSET_BINARY != 0) ? {1'b1, {(W-1){1'b0}}} : '0;
    localparam logic [W-1:0] SQ_HIGH  = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SQ_LOW   = {1'b1, {(W-1){1'b0}}};

    state_t state, state_nxt;

    logic [1:0]         mode_q;
    logic [15:0]        burst_len_q;
    logic [W-1:0]       step_q;
    logic [7:0]         sq_half_q;
    logic [W-1:0]       const_q;
    logic [15:0]        frame_cnt;
    logic [W-1:0]       ramp_acc;
    logic [7:0]         sq_cnt;
    logic               sq_phase;

    logic               arm_accept;
    logic               start;
    logic               sq_last;
    logic               underflow_hit;
    logic [W-1:0]       acc;
    logic [LANES*W-1:0] ramp_frame;
    logic [LANES*W-1:0] frame;
    logic [LANES*W-1:0] coded;

    always_ff @(posedge sysclk_in or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arm) state_nxt = ARMED;
            ARMED:   if (trigger) state_nxt = RUN;
            RUN:     if (burst_len_q != 16'd0 && frame_cnt == burst_len_q - 16'd1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
        arm_accept = (state == IDLE) && arm && !abort;
        start      = (state == ARMED) && trigger && !abort;
        sq_last    = (sq_cnt == ((sq_half_q == 8'd0) ? 8'd0 : sq_half_q - 8'd1));
    end

    // An aborted cycle already shows midscale so the abort takes effect on the very next edge.
    always_comb begin
        frame         = '0;
        underflow_hit = 1'b0;
        acc           = ramp_acc;
        ramp_frame    = '0;
        for (int i = 0; i < LANES; i++) begin
            ramp_frame[i*W +: W] = acc;
            acc = acc + step_q;
        end
        if (state == RUN && !abort) begin
            case (mode_q)
                2'd0: begin
                    if (src_valid) frame = src_data;
                    else           underflow_hit = 1'b1;
                end
                2'd1: frame = ramp_frame;
                2'd2: frame = {LANES{sq_phase ? SQ_HIGH : SQ_LOW}};
                default: frame = {LANES{const_q}};
            endcase
        end
        for (int i = 0; i < LANES; i++) begin
            coded[i*W +: W] = frame[i*W +: W] ^ MSB_MASK;
        end
    end

    always_ff @(posedge sysclk_in or posedge reset) begin
        if (reset) begin
            data_out      <= {LANES{MSB_MASK}};
            busy          <= 1'b0;
            underflow_cnt <= '0;
            mode_q        <= '0;
            burst_len_q   <= '0;
            step_q        <= '0;
            sq_half_q     <= '0;
            const_q       <= '0;
            frame_cnt     <= '0;
            ramp_acc      <= '0;
            sq_cnt        <= '0;
            sq_phase      <= 1'b0;
        end else begin
            data_out <= coded;
            busy     <= (state_nxt != IDLE);
            if (arm_accept)
                underflow_cnt <= '0;
            else if (underflow_hit && underflow_cnt != 16'hFFFF)
                underflow_cnt <= underflow_cnt + 16'd1;
            if (start) begin
                mode_q      <= mode;
                burst_len_q <= burst_len;
                step_q      <= ramp_step;
                sq_half_q   <= sq_half;
                const_q     <= const_val;
                frame_cnt   <= '0;
                ramp_acc    <= '0;
                sq_cnt      <= '0;
                sq_phase    <= 1'b1;
            end else if (state == RUN) begin
                frame_cnt <= frame_cnt + 16'd1;
                ramp_acc  <= acc;
                if (sq_last) begin
                    sq_cnt   <= '0;
                    sq_phase <= ~sq_phase;
                end else begin
                    sq_cnt <= sq_cnt + 8'd1;
                end
            end
        end
    end

endmodule
